imem_fetch_responder: RTL and testbench

Instruction-memory responder that services fetch requests issued by the program-counter side of the 64-bit core. It accepts a byte address per request over a valid/ready handshake and reads a 32-bit instruction word from an internal word array. It returns the word after a fixed pipeline latency and buffers responses in a small FIFO so the consumer can apply backpressure. A load port fills the array before execution, and a flush input discards all in-flight fetches on redirect.

---
 rtl/imem_fetch_responder_pkg.sv | 23 ++
 rtl/imem_fetch_responder_if.sv | 30 +++
 rtl/imem_fetch_responder_resp_fifo.sv | 61 ++++++
 rtl/imem_fetch_responder.sv | 112 +++++++++++
 tb/tb_imem_fetch_responder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared definitions for the instruction-memory fetch responder.
//   INSTR_WIDTH      : width of one instruction word
//   ERR_NONE/FETCH   : value of the response error flag
//   fetch_word_index : word index selected by a byte address
//   fetch_addr_err   : misaligned or beyond-array flag for a byte address
package imem_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic ERR_NONE  = 1'b0;
  localparam logic ERR_FETCH = 1'b1;

  // Byte address to word index; idx_w is log2 of the array depth.
  function automatic logic [63:0] fetch_word_index(input logic [63:0] addr, input int idx_w);
    return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Error when the address is not word aligned or any bit above the index is set.
  function automatic logic fetch_addr_err(input logic [63:0] addr, input int idx_w);
    return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 64'd0);
  endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response bus between the PC side and the instruction memory.
//   req_valid/req_ready/req_addr          : byte-address fetch request
//   rsp_valid/rsp_ready/rsp_data/rsp_addr/rsp_err : in-order fetch response
// master = requester (core), slave = responder (memory).
interface imem_fetch_responder_if
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
);

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [INSTR_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0]  rsp_addr;
  logic                   rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

endinterface

// File: rtl/imem_fetch_responder_resp_fifo.sv
// Synchronous response FIFO with push, pop and flush.
//   clk, reset (active-low, synchronous), flush : control
//   push/push_data : write one entry (ignored when full unless popping)
//   pop            : drop the head entry (ignored when empty)
//   head           : entry at the read pointer
//   count          : number of stored entries
// Storage is not reset; only pointers and count are.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder.
//   clk, reset (active-low, synchronous)
//   bus     : slave side of the fetch request/response interface
//   flush   : discard every accepted but undelivered fetch
//   load_en/load_addr/load_data : write one word into the instruction array
// Requests are read through a LATENCY-stage pipeline into a response FIFO.
// An outstanding counter covering pipeline plus FIFO gates req_ready so the
// FIFO can never overflow while the consumer applies backpressure.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_fetch_responder_if.slave    bus,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]   load_data
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + INSTR_WIDTH;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0]       outstanding;
  logic                   accept;
  logic                   pop;
  logic                   req_err;
  logic [IDX_W-1:0]       rd_idx;

  logic                   vld_p  [LATENCY];
  logic                   err_p  [LATENCY];
  logic [ADDR_WIDTH-1:0]  addr_p [LATENCY];
  logic [INSTR_WIDTH-1:0] word_p [LATENCY];

  logic [ENTRY_W-1:0]     head;
  logic [CNT_W-1:0]       fifo_count;

  assign bus.req_ready = (outstanding < CNT_W'(FIFO_DEPTH)) && !flush;
  assign accept        = bus.req_valid && bus.req_ready;
  // A handshake seen during flush is void: the entry is dropped, not delivered.
  assign pop           = bus.rsp_valid && bus.rsp_ready && !flush;

  assign req_err = fetch_addr_err(64'(bus.req_addr), IDX_W);
  assign rd_idx  = IDX_W'(fetch_word_index(64'(bus.req_addr), IDX_W));

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      outstanding <= '0;
    end else if (accept && !pop) begin
      outstanding <= outstanding + 1'b1;
    end else if (pop && !accept) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Array write; the stage-0 read in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (reset && load_en) mem[load_addr] <= load_data;
  end

  // Stage 0: capture address, error flag and array read
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int s = 0; s < LATENCY; s++) vld_p[s] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p[0] <= bus.req_addr;
      err_p[0]  <= req_err;
      word_p[0] <= (req_err == ERR_FETCH) ? '0 : mem[rd_idx];
    end
    // Stages 1..LATENCY-1: delay line towards the FIFO
    for (int s = 1; s < LATENCY; s++) begin
      addr_p[s] <= addr_p[s-1];
      err_p[s]  <= err_p[s-1];
      word_p[s] <= word_p[s-1];
    end
  end

  // FIFO entry: last pipeline stage pushes on the following edge
  resp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (vld_p[LATENCY-1]),
    .push_data ({err_p[LATENCY-1], addr_p[LATENCY-1], word_p[LATENCY-1]}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Outputs read zero whenever nothing is presented.
  assign bus.rsp_valid = (fifo_count != '0);
  assign {bus.rsp_err, bus.rsp_addr, bus.rsp_data} = bus.rsp_valid ? head : '0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

  localparam int ADDR_WIDTH = 64;
  localparam int DEPTH      = 1024;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = $clog2(DEPTH);

  typedef struct {
    logic [63:0] addr;
    logic        err;
    logic [31:0] data;
    int          rdy;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             load_en;
  logic [IDX_W-1:0] load_addr;
  logic [31:0]      load_data;
  logic             r_valid;
  logic [63:0]      r_addr;
  logic             r_ready;

  int vectors;
  int errors;
  int cyc;

  logic [31:0] mm [DEPTH];
  exp_t q[$];
  rsp_t got[$];

  imem_fetch_responder_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  assign bus.req_valid = r_valid;
  assign bus.req_addr  = r_addr;
  assign bus.rsp_ready = r_ready;

  imem_fetch_responder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs with the reference queue, then advance it.
  task automatic cycle();
    logic        m_ready;
    logic        m_valid;
    logic        acc;
    logic        pp;
    exp_t        e;
    exp_t        h;
    rsp_t        r;
    logic [63:0] ed;
    logic [63:0] ea;
    logic        ee;
    #1;
    m_ready = (q.size() < FIFO_DEPTH) && !flush;
    m_valid = 1'b0;
    ed = '0;
    ea = '0;
    ee = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      if (h.rdy <= cyc) begin
        m_valid = 1'b1;
        ed = {32'd0, h.data};
        ea = h.addr;
        ee = h.err;
      end
    end
    chk("req_ready", {63'd0, bus.req_ready}, {63'd0, m_ready});
    chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, m_valid});
    chk("rsp_data",  {32'd0, bus.rsp_data}, ed);
    chk("rsp_addr",  bus.rsp_addr, ea);
    chk("rsp_err",   {63'd0, bus.rsp_err}, {63'd0, ee});

    if (reset && !flush && bus.rsp_valid && r_ready) begin
      r.addr = bus.rsp_addr;
      r.err  = bus.rsp_err;
      r.data = bus.rsp_data;
      got.push_back(r);
    end

    acc = r_valid && m_ready;
    pp  = m_valid && r_ready;
    if (!reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
      if (load_en) mm[load_addr] = load_data;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.addr = r_addr;
        e.err  = (r_addr[1:0] != 2'b00) || ((r_addr >> 2) >= 64'(DEPTH));
        e.data = e.err ? 32'd0 : mm[IDX_W'(r_addr >> 2)];
        e.rdy  = cyc + 1 + LATENCY;
        q.push_back(e);
      end
      if (load_en) mm[load_addr] = load_data;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic req(input logic [63:0] a);
    r_valid = 1'b1;
    r_addr  = a;
    cycle();
    r_valid = 1'b0;
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = IDX_W'(idx);
    load_data = d;
    cycle();
    load_en   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [31:0] d, input logic err);
    logic [63:0] od;
    logic [63:0] oe;
    od = 64'hDEAD_0000_0000_0000;
    oe = 64'hDEAD_0000_0000_0000;
    if (idx < got.size()) begin
      od = {32'd0, got[idx].data};
      oe = {63'd0, got[idx].err};
    end
    chk({tag, "_data"}, od, {32'd0, d});
    chk({tag, "_err"}, oe, {63'd0, err});
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    cyc       = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    r_valid   = 1'b0;
    r_addr    = '0;
    r_ready   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_data",  {32'd0, bus.rsp_data}, 64'd0);

    for (int i = 0; i < 16; i++) load_word(i, 32'h13 + 32'(i));

    // back-to-back fetches with the consumer always ready
    got.delete();
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) req(64'(i * 4));
    drain();
    chk("b2b_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_got("b2b", i, 32'h13 + 32'(i), 1'b0);

    // backpressure: only FIFO_DEPTH requests are taken
    got.delete();
    r_ready = 1'b0;
    for (int i = 0; i < 6; i++) req(64'(16 + i * 4));
    #1;
    chk("bp_req_ready_low", {63'd0, bus.req_ready}, 64'd0);
    r_ready = 1'b1;
    cycle();
    #1;
    chk("bp_req_ready_back", {63'd0, bus.req_ready}, 64'd1);
    drain();
    chk("bp_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_got("bp", i, 32'h17 + 32'(i), 1'b0);

    // error addresses
    got.delete();
    req(64'h6);
    req(64'(4 * DEPTH));
    req(64'hFFFF_FFFF_FFFF_FFFC);
    drain();
    chk_got("err_misaligned", 0, 32'd0, 1'b1);
    chk_got("err_range", 1, 32'd0, 1'b1);
    chk_got("err_high", 2, 32'd0, 1'b1);

    // flush with one entry in the FIFO and two in the pipeline
    r_ready = 1'b0;
    req(64'h20);
    req(64'h24);
    req(64'h28);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    got.delete();
    r_ready = 1'b1;
    req(64'h0);
    drain();
    chk("flush_count", 64'(got.size()), 64'd1);
    chk_got("flush_word0", 0, 32'h13, 1'b0);

    // reset with two FIFO entries; array contents survive
    r_ready = 1'b0;
    req(64'h4);
    req(64'h8);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    got.delete();
    r_ready = 1'b1;
    req(64'h4);
    drain();
    chk_got("rst_retain", 0, 32'h14, 1'b0);

    // load and fetch of the same word in one cycle
    got.delete();
    load_en   = 1'b1;
    load_addr = IDX_W'(2);
    load_data = 32'hDEAD_BEEF;
    req(64'h8);
    load_en = 1'b0;
    req(64'h8);
    drain();
    chk_got("rbw_old", 0, 32'h15, 1'b0);
    chk_got("rbw_new", 1, 32'hDEAD_BEEF, 1'b0);

    // randomized traffic against the reference queue
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel     = int'($urandom % 16);
      r_valid = ($urandom % 4) != 0;
      if (sel < 12)       r_addr = 64'(($urandom % 16) * 4);
      else if (sel == 12) r_addr = 64'(($urandom % 16) * 4 + 1 + ($urandom % 3));
      else if (sel == 13) r_addr = 64'(4 * DEPTH) + 64'(($urandom % 64) * 4);
      else if (sel == 14) r_addr = {$urandom | 32'h1, $urandom} & ~64'h3;
      else                r_addr = 64'h3C;
      r_ready   = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      load_en   = ($urandom % 10) == 0;
      load_addr = IDX_W'($urandom % 16);
      load_data = $urandom;
      reset     = ($urandom % 150) != 0;
      cycle();
    end
    r_valid = 1'b0;
    flush   = 1'b0;
    load_en = 1'b0;
    reset   = 1'b1;
    r_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
